dot_prod_sched: RTL and testbench
=================================

# dot_prod_sched

Frame-level scheduler for the complex dot-product engine in the CAF datapath. It buffers one reference window of `length` complex samples and one received frame of `length+num_shifts-1` samples. For each shift 0..num_shifts-1 it issues exactly one dot-product request, collects the engine's I/Q result, and forwards it with its shift index. It also tracks the peak |i|+|q| across the frame and reports the winning shift when the frame ends.

## Interface
- `xi_bits`, 12: reference I width. `xq_bits`, 12: reference Q width. `yi_bits`, 12: received I width. `yq_bits`, 12: received Q width.
- `i_bits`, 24: engine I result width. `q_bits`, 24: engine Q result width.
- `length`, 5: samples per dot product.
- `num_shifts`, 8: shifts evaluated per frame, ≥1.
- `shift_bits`, 3: width of shift index, ≥ clog2(num_shifts).
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `m_axis_ref_tvalid` in 1, `ref_i` in xi_bits, `ref_q` in xq_bits, `s_axis_ref_tready` out 1: serial reference load.
- `m_axis_rx_tvalid` in 1, `rx_i` in yi_bits, `rx_q` in yq_bits, `s_axis_rx_tready` out 1: serial received-sample load.
- `eng_xi`/`eng_xq` out xi_bits*length / xq_bits*length; `eng_yi`/`eng_yq` out yi_bits*length / yq_bits*length: packed windows to the engine.
- `eng_x_tvalid`, `eng_y_tvalid` out 1: request strobes to the engine.
- `eng_product_tready` out 1: scheduler ready for a result.
- `eng_product_tvalid` in 1, `eng_i` in i_bits, `eng_q` in q_bits: engine result.
- `s_axis_corr_tvalid` out 1, `corr_i` out i_bits, `corr_q` out q_bits, `corr_shift` out shift_bits, `m_axis_corr_tready` in 1: per-shift result.
- `s_axis_peak_tvalid` out 1, `peak_shift` out shift_bits, `peak_mag` out i_bits+1: end-of-frame peak report, one-cycle pulse.
- `busy` out 1: high in every state except LOAD_REF.

## Operation
- States: LOAD_REF, LOAD_RX, ISSUE, WAIT, EMIT, DONE. Reset enters LOAD_REF.
- **LOAD_REF**
  - `s_axis_ref_tready` = 1. A sample is accepted when valid & ready.
  - The n-th accepted sample is stored as window element n at bits [bits*n +: bits]. Element 0 is the oldest.
  - After `length` accepts, go to LOAD_RX.
- **LOAD_RX**
  - `s_axis_rx_tready` = 1. Accepts `length+num_shifts-1` samples, indexed the same way.
  - After the last accept, clear shift to 0 and the peak to 0/0, then go to ISSUE.
- **ISSUE**
  - Drive `eng_x*` from the reference and `eng_y*` from rx elements shift..shift+length-1, element 0 = rx[shift].
  - Pulse `eng_x_tvalid` and `eng_y_tvalid` together for exactly one cycle, then go to WAIT.
  - `eng_x*`/`eng_y*` hold their values until the next ISSUE.
- **WAIT**
  - `eng_product_tready` = 1. On `eng_product_tvalid`, capture `eng_i`/`eng_q` and go to EMIT.
  - `eng_product_tvalid` outside WAIT is ignored.
- **EMIT**
  - `s_axis_corr_tvalid` = 1 with the captured result and `corr_shift` = shift. Outputs are stable until `m_axis_corr_tready`.
  - On the handshake:
    - mag = |corr_i| + |corr_q|, computed unsigned at i_bits+1 bits (requires q_bits ≤ i_bits). The most negative value maps to its true magnitude.
    - If mag > peak_mag, update the peak. Strictly greater, so a tie keeps the earliest shift.
    - If shift = num_shifts-1, go to DONE; otherwise increment shift and go to ISSUE.
- **DONE**: pulse `s_axis_peak_tvalid` for one cycle. Go to LOAD_REF; the reference is reloaded every frame.

## Timing
- Reset values: all tvalid/tready outputs 0, `busy` 0, all data outputs 0, shift 0, peak 0.
- Load throughput: one sample per cycle when the source is valid.
- Per shift, ISSUE to EMIT takes 1 + engine latency + 1 cycles. EMIT holds for at least 1 cycle.
- Minimum frame length:
  - ref: `length` cycles, plus
  - rx: `length+num_shifts-1` cycles, plus
  - per shift: num_shifts*(engine latency + 3) cycles, plus
  - DONE: 1 cycle.
- Any reset assertion aborts a frame mid-operation. The next cycle shows reset values, and the buffers are treated as empty.
- A result arriving in the same cycle as the WAIT entry cannot occur: the engine latency is ≥1.
- Backpressure on corr stalls the whole schedule; no request is issued while a result is pending.

## Structure
- A shared package holds the state enumeration and a `mag_abs_sum` function.
- Natural sub-module: `sample_window_buf`, a serial-in, parallel packed-out sample buffer. Instantiate it twice (ref, rx) with depth parameters.
- The dot-product engine stays outside; connect it at the top level.

## Test plan
- length=5, num_shifts=4, ref = 1+0j ×5, rx = 0..7 real, behavioural engine with 3-cycle latency.
  - Expect corr_i = 10, 15, 20, 25 at shifts 0..3, corr_q = 0.
  - Expect peak_shift = 3, peak_mag = 25.
- Same stimulus with `m_axis_corr_tready` low for 5 cycles at shift 1: corr data is held stable, no new `eng_x_tvalid` appears, and the frame completes with the same results.
- Equal magnitudes at shifts 1 and 2, for example rx symmetric so both give 20: peak_shift = 1.
- corr_i = -2^23, corr_q = 0 at shift 0: peak_mag = 2^23 with no overflow.
- Reset asserted in WAIT at shift 2:
  - Next cycle all outputs are 0 and the state is LOAD_REF.
  - A late `eng_product_tvalid` is ignored.
  - A full new frame then completes correctly.
- Gapped loads with the valid toggling every other cycle: the buffers fill in the correct order, and results match the first scenario.

Source files
------------

// File: rtl/dot_prod_sched_pkg.sv
// -----------------------------------------------------------------------------
// dot_prod_sched_pkg
// Shared definitions for the CAF dot-product scheduler:
//   - state_t     : scheduler state enumeration
//   - mag_abs_sum : |a| + |b| on sign-extended 64-bit operands, so the most
//                   negative input of any narrower width maps to its true
//                   magnitude without wrapping.
// -----------------------------------------------------------------------------
package dot_prod_sched_pkg;

  typedef enum logic [2:0] {
    LOAD_REF = 3'd0,
    LOAD_RX  = 3'd1,
    ISSUE    = 3'd2,
    WAIT     = 3'd3,
    EMIT     = 3'd4,
    DONE     = 3'd5
  } state_t;

  // Callers sign-extend into 64 bits and size-cast the result down to the
  // width they need; 64 bits leaves headroom for any realistic result width.
  function automatic logic [63:0] mag_abs_sum(input logic signed [63:0] a,
                                              input logic signed [63:0] b);
    logic [63:0] abs_a;
    logic [63:0] abs_b;
    abs_a = a[63] ? 64'(-a) : 64'(a);
    abs_b = b[63] ? 64'(-b) : 64'(b);
    return abs_a + abs_b;
  endfunction

endpackage

// File: rtl/dot_prod_sched_sample_window_buf.sv
// -----------------------------------------------------------------------------
// sample_window_buf
// Serial-in, parallel packed-out complex sample buffer. The n-th accepted
// sample lands in element n (bits [BITS*n +: BITS]); element 0 is the oldest.
// The write index wraps to 0 after DEPTH writes, so the next frame refills
// from element 0 without an explicit clear.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   i_wr_en           : accept i_data_i / i_data_q this cycle
//   i_data_i/i_data_q : incoming sample
//   o_win_i/o_win_q   : packed window, DEPTH elements
//   o_last            : high on the write that fills the final element
// -----------------------------------------------------------------------------
module sample_window_buf #(
  parameter int I_BITS = 12,
  parameter int Q_BITS = 12,
  parameter int DEPTH  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_wr_en,
  input  logic [I_BITS-1:0]         i_data_i,
  input  logic [Q_BITS-1:0]         i_data_q,
  output logic [I_BITS*DEPTH-1:0]   o_win_i,
  output logic [Q_BITS*DEPTH-1:0]   o_win_q,
  output logic                      o_last
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IDX_W-1:0]  r_idx;
  logic [I_BITS-1:0] r_mem_i [DEPTH];
  logic [Q_BITS-1:0] r_mem_q [DEPTH];

  assign o_last = i_wr_en && (r_idx == IDX_W'(DEPTH - 1));

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx <= '0;
    end else if (i_wr_en) begin
      r_idx <= o_last ? '0 : r_idx + 1'b1;
    end
  end

  // NOTE: the sample storage carries no reset; only the write index does.
  // Stale contents are never consumed because a frame always refills every
  // element before the scheduler reads the window.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem_i[r_idx] <= i_data_i;
      r_mem_q[r_idx] <= i_data_q;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_pack
    assign o_win_i[I_BITS*k +: I_BITS] = r_mem_i[k];
    assign o_win_q[Q_BITS*k +: Q_BITS] = r_mem_q[k];
  end

endmodule

// File: rtl/dot_prod_sched.sv
// -----------------------------------------------------------------------------
// dot_prod_sched
// Frame scheduler for the external complex dot-product engine. Loads one
// reference window (LENGTH samples) and one received frame
// (LENGTH+NUM_SHIFTS-1 samples), then for each shift issues one engine
// request, waits for the I/Q result, forwards it with its shift index, and
// tracks the peak |i|+|q|. A one-cycle peak report closes each frame.
//
// Ports:
//   clk, reset                                  : clock, sync active-high reset
//   m_axis_ref_tvalid, ref_i, ref_q,
//     s_axis_ref_tready                         : serial reference load
//   m_axis_rx_tvalid, rx_i, rx_q,
//     s_axis_rx_tready                          : serial received-sample load
//   eng_xi, eng_xq, eng_yi, eng_yq              : packed windows to engine
//   eng_x_tvalid, eng_y_tvalid                  : one-cycle request strobes
//   eng_product_tready, eng_product_tvalid,
//     eng_i, eng_q                              : engine result
//   s_axis_corr_tvalid, corr_i, corr_q,
//     corr_shift, m_axis_corr_tready            : per-shift result
//   s_axis_peak_tvalid, peak_shift, peak_mag    : end-of-frame peak report
//   busy                                        : low only in LOAD_REF
// -----------------------------------------------------------------------------
module dot_prod_sched
  import dot_prod_sched_pkg::*;
#(
  parameter int XI_BITS    = 12,
  parameter int XQ_BITS    = 12,
  parameter int YI_BITS    = 12,
  parameter int YQ_BITS    = 12,
  parameter int I_BITS     = 24,
  parameter int Q_BITS     = 24,
  parameter int LENGTH     = 5,
  parameter int NUM_SHIFTS = 8,
  parameter int SHIFT_BITS = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  // reference load
  input  logic                        m_axis_ref_tvalid,
  input  logic [XI_BITS-1:0]          ref_i,
  input  logic [XQ_BITS-1:0]          ref_q,
  output logic                        s_axis_ref_tready,
  // received-sample load
  input  logic                        m_axis_rx_tvalid,
  input  logic [YI_BITS-1:0]          rx_i,
  input  logic [YQ_BITS-1:0]          rx_q,
  output logic                        s_axis_rx_tready,
  // engine request
  output logic [XI_BITS*LENGTH-1:0]   eng_xi,
  output logic [XQ_BITS*LENGTH-1:0]   eng_xq,
  output logic [YI_BITS*LENGTH-1:0]   eng_yi,
  output logic [YQ_BITS*LENGTH-1:0]   eng_yq,
  output logic                        eng_x_tvalid,
  output logic                        eng_y_tvalid,
  // engine result
  output logic                        eng_product_tready,
  input  logic                        eng_product_tvalid,
  input  logic [I_BITS-1:0]           eng_i,
  input  logic [Q_BITS-1:0]           eng_q,
  // per-shift result
  output logic                        s_axis_corr_tvalid,
  output logic [I_BITS-1:0]           corr_i,
  output logic [Q_BITS-1:0]           corr_q,
  output logic [SHIFT_BITS-1:0]       corr_shift,
  input  logic                        m_axis_corr_tready,
  // peak report
  output logic                        s_axis_peak_tvalid,
  output logic [SHIFT_BITS-1:0]       peak_shift,
  output logic [I_BITS:0]             peak_mag,
  output logic                        busy
);

  localparam int RX_DEPTH = LENGTH + NUM_SHIFTS - 1;

  state_t                      r_state;
  logic [SHIFT_BITS-1:0]       r_shift;
  logic                        r_ref_tready;
  logic                        r_rx_tready;
  logic                        r_eng_tvalid;
  logic                        r_prod_tready;
  logic [XI_BITS*LENGTH-1:0]   r_eng_xi;
  logic [XQ_BITS*LENGTH-1:0]   r_eng_xq;
  logic [YI_BITS*LENGTH-1:0]   r_eng_yi;
  logic [YQ_BITS*LENGTH-1:0]   r_eng_yq;
  logic                        r_corr_tvalid;
  logic [I_BITS-1:0]           r_corr_i;
  logic [Q_BITS-1:0]           r_corr_q;
  logic                        r_peak_tvalid;
  logic [SHIFT_BITS-1:0]       r_peak_shift;
  logic [I_BITS:0]             r_peak_mag;
  logic                        r_busy;

  logic                        w_ref_we;
  logic                        w_rx_we;
  logic                        w_ref_last;
  logic                        w_rx_last;
  logic [XI_BITS*LENGTH-1:0]   w_ref_win_i;
  logic [XQ_BITS*LENGTH-1:0]   w_ref_win_q;
  logic [YI_BITS*RX_DEPTH-1:0] w_rx_win_i;
  logic [YQ_BITS*RX_DEPTH-1:0] w_rx_win_q;
  logic [I_BITS:0]             w_mag;

  // Ready flags are only ever high in their own load state.
  assign w_ref_we = m_axis_ref_tvalid & r_ref_tready;
  assign w_rx_we  = m_axis_rx_tvalid  & r_rx_tready;

  sample_window_buf #(
    .I_BITS (XI_BITS),
    .Q_BITS (XQ_BITS),
    .DEPTH  (LENGTH)
  ) u_ref_buf (
    .clk      (clk),
    .reset    (reset),
    .i_wr_en  (w_ref_we),
    .i_data_i (ref_i),
    .i_data_q (ref_q),
    .o_win_i  (w_ref_win_i),
    .o_win_q  (w_ref_win_q),
    .o_last   (w_ref_last)
  );

  sample_window_buf #(
    .I_BITS (YI_BITS),
    .Q_BITS (YQ_BITS),
    .DEPTH  (RX_DEPTH)
  ) u_rx_buf (
    .clk      (clk),
    .reset    (reset),
    .i_wr_en  (w_rx_we),
    .i_data_i (rx_i),
    .i_data_q (rx_q),
    .o_win_i  (w_rx_win_i),
    .o_win_q  (w_rx_win_q),
    .o_last   (w_rx_last)
  );

  // Magnitude of the result currently on offer; q is sign-extended to the
  // same 64-bit domain so mixed widths (q_bits <= i_bits) sum correctly.
  assign w_mag = (I_BITS + 1)'(mag_abs_sum(64'($signed(r_corr_i)),
                                           64'($signed(r_corr_q))));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= LOAD_REF;
      r_shift       <= '0;
      r_ref_tready  <= 1'b0;
      r_rx_tready   <= 1'b0;
      r_eng_tvalid  <= 1'b0;
      r_prod_tready <= 1'b0;
      r_eng_xi      <= '0;
      r_eng_xq      <= '0;
      r_eng_yi      <= '0;
      r_eng_yq      <= '0;
      r_corr_tvalid <= 1'b0;
      r_corr_i      <= '0;
      r_corr_q      <= '0;
      r_peak_tvalid <= 1'b0;
      r_peak_shift  <= '0;
      r_peak_mag    <= '0;
      r_busy        <= 1'b0;
    end else begin
      // Strobes default low so each is a single-cycle pulse.
      r_eng_tvalid  <= 1'b0;
      r_peak_tvalid <= 1'b0;

      case (r_state)
        LOAD_REF: begin
          r_ref_tready <= 1'b1;
          if (w_ref_last) begin
            r_ref_tready <= 1'b0;
            r_rx_tready  <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= LOAD_RX;
          end
        end

        LOAD_RX: begin
          if (w_rx_last) begin
            r_rx_tready  <= 1'b0;
            r_shift      <= '0;
            r_peak_shift <= '0;
            r_peak_mag   <= '0;
            r_state      <= ISSUE;
          end
        end

        ISSUE: begin
          // Window element 0 is rx[shift]; the slice slides one element
          // per shift across the received frame.
          r_eng_xi      <= w_ref_win_i;
          r_eng_xq      <= w_ref_win_q;
          r_eng_yi      <= w_rx_win_i[YI_BITS*r_shift +: YI_BITS*LENGTH];
          r_eng_yq      <= w_rx_win_q[YQ_BITS*r_shift +: YQ_BITS*LENGTH];
          r_eng_tvalid  <= 1'b1;
          r_prod_tready <= 1'b1;
          r_state       <= WAIT;
        end

        WAIT: begin
          if (eng_product_tvalid) begin
            r_corr_i      <= eng_i;
            r_corr_q      <= eng_q;
            r_prod_tready <= 1'b0;
            r_corr_tvalid <= 1'b1;
            r_state       <= EMIT;
          end
        end

        EMIT: begin
          if (m_axis_corr_tready) begin
            r_corr_tvalid <= 1'b0;
            // Strictly greater: on a tie the earliest shift keeps the peak.
            if (w_mag > r_peak_mag) begin
              r_peak_mag   <= w_mag;
              r_peak_shift <= r_shift;
            end
            if (r_shift == SHIFT_BITS'(NUM_SHIFTS - 1)) begin
              r_peak_tvalid <= 1'b1;
              r_state       <= DONE;
            end else begin
              r_shift <= r_shift + 1'b1;
              r_state <= ISSUE;
            end
          end
        end

        DONE: begin
          // Raise ref ready now so the next frame loads without a dead cycle.
          r_busy       <= 1'b0;
          r_ref_tready <= 1'b1;
          r_state      <= LOAD_REF;
        end

        default: r_state <= LOAD_REF;
      endcase
    end
  end

  assign s_axis_ref_tready  = r_ref_tready;
  assign s_axis_rx_tready   = r_rx_tready;
  assign eng_xi             = r_eng_xi;
  assign eng_xq             = r_eng_xq;
  assign eng_yi             = r_eng_yi;
  assign eng_yq             = r_eng_yq;
  assign eng_x_tvalid       = r_eng_tvalid;
  assign eng_y_tvalid       = r_eng_tvalid;
  assign eng_product_tready = r_prod_tready;
  assign s_axis_corr_tvalid = r_corr_tvalid;
  assign corr_i             = r_corr_i;
  assign corr_q             = r_corr_q;
  assign corr_shift         = r_shift;
  assign s_axis_peak_tvalid = r_peak_tvalid;
  assign peak_shift         = r_peak_shift;
  assign peak_mag           = r_peak_mag;
  assign busy               = r_busy;

endmodule

// File: tb/tb_dot_prod_sched.sv
// -----------------------------------------------------------------------------
// tb_dot_prod_sched
// Self-checking bench for dot_prod_sched (LENGTH=5, NUM_SHIFTS=4) with a
// behavioural 3-cycle-latency engine. Expected correlations and the frame
// peak are computed directly from the loaded sample arrays.
// -----------------------------------------------------------------------------
module tb_dot_prod_sched;
  import dot_prod_sched_pkg::*;

  localparam int LEN     = 5;
  localparam int NS      = 4;
  localparam int SB      = 3;
  localparam int W       = 12;
  localparam int IW      = 24;
  localparam int RXD     = LEN + NS - 1;
  localparam int ENG_LAT = 3;

  logic              clk;
  logic              reset;
  logic              m_axis_ref_tvalid;
  logic [W-1:0]      ref_i, ref_q;
  logic              s_axis_ref_tready;
  logic              m_axis_rx_tvalid;
  logic [W-1:0]      rx_i, rx_q;
  logic              s_axis_rx_tready;
  logic [W*LEN-1:0]  eng_xi, eng_xq, eng_yi, eng_yq;
  logic              eng_x_tvalid, eng_y_tvalid;
  logic              eng_product_tready;
  logic              eng_product_tvalid;
  logic [IW-1:0]     eng_i, eng_q;
  logic              s_axis_corr_tvalid;
  logic [IW-1:0]     corr_i, corr_q;
  logic [SB-1:0]     corr_shift;
  logic              m_axis_corr_tready;
  logic              s_axis_peak_tvalid;
  logic [SB-1:0]     peak_shift;
  logic [IW:0]       peak_mag;
  logic              busy;

  dot_prod_sched #(
    .XI_BITS(W), .XQ_BITS(W), .YI_BITS(W), .YQ_BITS(W),
    .I_BITS(IW), .Q_BITS(IW), .LENGTH(LEN), .NUM_SHIFTS(NS), .SHIFT_BITS(SB)
  ) dut (
    .clk(clk), .reset(reset),
    .m_axis_ref_tvalid(m_axis_ref_tvalid), .ref_i(ref_i), .ref_q(ref_q),
    .s_axis_ref_tready(s_axis_ref_tready),
    .m_axis_rx_tvalid(m_axis_rx_tvalid), .rx_i(rx_i), .rx_q(rx_q),
    .s_axis_rx_tready(s_axis_rx_tready),
    .eng_xi(eng_xi), .eng_xq(eng_xq), .eng_yi(eng_yi), .eng_yq(eng_yq),
    .eng_x_tvalid(eng_x_tvalid), .eng_y_tvalid(eng_y_tvalid),
    .eng_product_tready(eng_product_tready),
    .eng_product_tvalid(eng_product_tvalid), .eng_i(eng_i), .eng_q(eng_q),
    .s_axis_corr_tvalid(s_axis_corr_tvalid), .corr_i(corr_i), .corr_q(corr_q),
    .corr_shift(corr_shift), .m_axis_corr_tready(m_axis_corr_tready),
    .s_axis_peak_tvalid(s_axis_peak_tvalid), .peak_shift(peak_shift),
    .peak_mag(peak_mag), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus arrays and reference model
  // ---------------------------------------------------------------------------
  int ref_i_a [LEN];
  int ref_q_a [LEN];
  int rx_i_a  [RXD];
  int rx_q_a  [RXD];

  logic [IW-1:0] exp_i [NS];
  logic [IW-1:0] exp_q [NS];
  int            exp_pk_shift;
  logic [IW:0]   exp_pk_mag;

  // Complex dot product of the reference against rx[s .. s+LEN-1]; the
  // peak is the first shift with the largest |i|+|q|.
  task automatic compute_expected(input bit ovr);
    longint si, sq, mag, best;
    best = 0;
    exp_pk_shift = 0;
    for (int s = 0; s < NS; s++) begin
      si = 0;
      sq = 0;
      for (int k = 0; k < LEN; k++) begin
        si += longint'(ref_i_a[k]) * rx_i_a[s+k] - longint'(ref_q_a[k]) * rx_q_a[s+k];
        sq += longint'(ref_i_a[k]) * rx_q_a[s+k] + longint'(ref_q_a[k]) * rx_i_a[s+k];
      end
      if (ovr && s == 0) begin
        si = -(longint'(1) << 23);
        sq = 0;
      end
      exp_i[s] = IW'(si);
      exp_q[s] = IW'(sq);
      mag = ((si < 0) ? -si : si) + ((sq < 0) ? -sq : sq);
      if (mag > best) begin
        best = mag;
        exp_pk_shift = s;
      end
    end
    exp_pk_mag = (IW+1)'(best);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural engine: 3-cycle latency, optional one-shot forced result
  // ---------------------------------------------------------------------------
  int            eng_cnt = 0;
  logic [IW-1:0] pend_i, pend_q;
  bit            ovr_once = 1'b0;

  initial begin : engine
    longint si, sq, xi, xq, yi, yq;
    eng_product_tvalid = 1'b0;
    eng_i = '0;
    eng_q = '0;
    forever begin
      @(negedge clk);
      eng_product_tvalid = 1'b0;
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_product_tvalid = 1'b1;
          eng_i = pend_i;
          eng_q = pend_q;
        end
      end
      if (eng_x_tvalid && eng_y_tvalid) begin
        si = 0;
        sq = 0;
        for (int k = 0; k < LEN; k++) begin
          xi = longint'($signed(eng_xi[W*k +: W]));
          xq = longint'($signed(eng_xq[W*k +: W]));
          yi = longint'($signed(eng_yi[W*k +: W]));
          yq = longint'($signed(eng_yq[W*k +: W]));
          si += xi * yi - xq * yq;
          sq += xi * yq + xq * yi;
        end
        pend_i = IW'(si);
        pend_q = IW'(sq);
        if (ovr_once) begin
          pend_i = 24'h800000;
          pend_q = '0;
          ovr_once = 1'b0;
        end
        eng_cnt = ENG_LAT;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load tasks: called at a negedge, return at the negedge after acceptance
  // ---------------------------------------------------------------------------
  task automatic push_ref(input int di, input int dq);
    int guard = 0;
    m_axis_ref_tvalid = 1'b1;
    ref_i = W'(di);
    ref_q = W'(dq);
    while (!s_axis_ref_tready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("ref_ready_timeout", 64'(s_axis_ref_tready), 64'(1));
    @(negedge clk);
    m_axis_ref_tvalid = 1'b0;
  endtask

  task automatic push_rx(input int di, input int dq);
    int guard = 0;
    m_axis_rx_tvalid = 1'b1;
    rx_i = W'(di);
    rx_q = W'(dq);
    while (!s_axis_rx_tready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("rx_ready_timeout", 64'(s_axis_rx_tready), 64'(1));
    @(negedge clk);
    m_axis_rx_tvalid = 1'b0;
  endtask

  task automatic load_frame(input bit gap);
    for (int k = 0; k < LEN; k++) begin
      if (gap) @(negedge clk);
      push_ref(ref_i_a[k], ref_q_a[k]);
    end
    for (int k = 0; k < RXD; k++) begin
      if (gap) @(negedge clk);
      push_rx(rx_i_a[k], rx_q_a[k]);
    end
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, "_ctrl"}, 64'({s_axis_ref_tready, s_axis_rx_tready, eng_x_tvalid,
                               eng_y_tvalid, eng_product_tready, s_axis_corr_tvalid,
                               s_axis_peak_tvalid, busy}), 64'(0));
    check({tag, "_data"}, 64'(|{eng_xi, eng_xq, eng_yi, eng_yq, corr_i, corr_q,
                               corr_shift, peak_shift, peak_mag}), 64'(0));
    check({tag, "_state"}, 64'(dut.r_state), 64'(LOAD_REF));
  endtask

  // One full frame. stall_shift: hold corr_tready low 5 cycles at that shift.
  // abort_shift: assert reset in WAIT at that shift and return.
  task automatic run_frame(input bit gap, input int stall_shift,
                           input int abort_shift, input bit ovr);
    int guard;
    int lat;
    int seen;
    compute_expected(ovr);
    ovr_once = ovr;
    load_frame(gap);
    for (int s = 0; s < NS; s++) begin
      guard = 0;
      while (!eng_x_tvalid && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 100) check("issue_timeout", 64'(eng_x_tvalid), 64'(1));
      check("xy_tvalid_pair", 64'(eng_y_tvalid), 64'(eng_x_tvalid));

      if (s == abort_shift) begin
        reset = 1'b1;
        @(negedge clk);
        check_all_reset("abort");
        reset = 1'b0;
        seen = 0;
        repeat (8) begin
          @(negedge clk);
          if (s_axis_corr_tvalid || eng_product_tready) seen++;
        end
        check("late_result_ignored", 64'(seen), 64'(0));
        check("ref_ready_after_abort", 64'(s_axis_ref_tready), 64'(1));
        return;
      end

      @(negedge clk);
      check("x_one_cycle", 64'(eng_x_tvalid), 64'(0));
      lat = 1;
      while (!s_axis_corr_tvalid && lat < 100) begin
        @(negedge clk);
        lat++;
      end
      check("issue_to_emit", 64'(lat), 64'(ENG_LAT + 1));
      check("corr_i", 64'(corr_i), 64'(exp_i[s]));
      check("corr_q", 64'(corr_q), 64'(exp_q[s]));
      check("corr_shift", 64'(corr_shift), 64'(SB'(s)));
      check("busy_mid_frame", 64'(busy), 64'(1));

      if (s == stall_shift) begin
        repeat (5) begin
          @(negedge clk);
          check("stall_corr_held", 64'({s_axis_corr_tvalid, corr_i, corr_q}),
                64'({1'b1, exp_i[s], exp_q[s]}));
          check("stall_no_issue", 64'(eng_x_tvalid), 64'(0));
        end
      end

      m_axis_corr_tready = 1'b1;
      @(negedge clk);
      m_axis_corr_tready = 1'b0;
    end

    guard = 0;
    while (!s_axis_peak_tvalid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("peak_tvalid", 64'(s_axis_peak_tvalid), 64'(1));
    check("peak_shift", 64'(peak_shift), 64'(SB'(exp_pk_shift)));
    check("peak_mag", 64'(peak_mag), 64'(exp_pk_mag));
    @(negedge clk);
    check("peak_one_cycle", 64'(s_axis_peak_tvalid), 64'(0));
    check("idle_after_frame", 64'(busy), 64'(0));
  endtask

  task automatic set_base();
    for (int k = 0; k < LEN; k++) begin
      ref_i_a[k] = 1;
      ref_q_a[k] = 0;
    end
    for (int k = 0; k < RXD; k++) begin
      rx_i_a[k] = k;
      rx_q_a[k] = 0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1;
    m_axis_ref_tvalid  = 1'b0;
    m_axis_rx_tvalid   = 1'b0;
    m_axis_corr_tready = 1'b0;
    ref_i = '0;
    ref_q = '0;
    rx_i  = '0;
    rx_q  = '0;
    repeat (3) @(negedge clk);
    check_all_reset("reset");
    reset = 1'b0;

    // Ramp: corr_i = 10,15,20,25; peak at shift 3 with magnitude 25.
    set_base();
    run_frame(1'b0, -1, -1, 1'b0);
    check("ramp_exp_peak", 64'(exp_pk_mag), 64'(25));

    // Same frame with corr backpressure at shift 1.
    run_frame(1'b0, 1, -1, 1'b0);

    // Tie between shifts 1 and 2 (both 20): earliest shift wins.
    set_base();
    rx_i_a = '{0, 4, 4, 4, 4, 4, 4, 0};
    run_frame(1'b0, -1, -1, 1'b0);

    // Most negative engine I at shift 0: magnitude 2^23 without wrap.
    set_base();
    run_frame(1'b0, -1, -1, 1'b1);

    // Valid toggling every other cycle on both loads.
    run_frame(1'b1, -1, -1, 1'b0);

    // Abort in WAIT at shift 2, then a clean frame.
    run_frame(1'b0, -1, 2, 1'b0);
    run_frame(1'b0, -1, -1, 1'b0);

    // Random complex frames, values kept small enough to fit 24-bit results.
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < LEN; k++) begin
        ref_i_a[k] = int'($urandom_range(1023)) - 512;
        ref_q_a[k] = int'($urandom_range(1023)) - 512;
      end
      for (int k = 0; k < RXD; k++) begin
        rx_i_a[k] = int'($urandom_range(1023)) - 512;
        rx_q_a[k] = int'($urandom_range(1023)) - 512;
      end
      run_frame(f[0], (f == 2) ? 3 : -1, -1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
